hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//   Next-generation ID-stage hazard unit for the 5-stage core: load-use stall plus a register
//   scoreboard for multi-cycle (MUL/DIV) writes, a structural limit on in-flight long ops,
//   EX-resolved branch flush, and a stall watchdog. Drives PC/IF_ID write enables and bubble insert.
// PARAMETERS
//   REG_AW      5   register address width; NUM_REGS = 2**REG_AW, x0 never tracked
//   MAX_LONG    2   max long ops in flight (1..2**REG_AW-1)
//   STALL_LIMIT 64  consecutive stall cycles before hazard_timeout sets (>=2)
// PORTS
//   clk             in  1      rising-edge clock
//   reset           in  1      asynchronous, active-high
//   id_valid        in  1      IF/ID holds a valid instruction
//   id_rs1/id_rs2   in  REG_AW source regs in IF/ID
//   id_use_rs1/rs2  in  1      instruction actually reads that source
//   id_long_op      in  1      IF/ID instruction is a MUL/DIV
//   ex_valid        in  1      ID/EX holds a valid instruction
//   ex_mem_read     in  1      ID/EX instruction is a load
//   ex_long_op      in  1      ID/EX instruction is a MUL/DIV (issues this cycle)
//   ex_rd           in  REG_AW ID/EX destination
//   long_done       in  1      a long op writes back this cycle
//   long_done_rd    in  REG_AW destination of that writeback
//   branch_taken    in  1      EX resolved a taken branch/jump
//   pc_write        out 1      PC update enable
//   if_id_write     out 1      IF/ID load enable
//   control_mux     out 1      1 = insert bubble into ID/EX
//   if_id_flush     out 1      clear IF/ID
//   busy_vec        out NUM_REGS scoreboard (bit 0 always 0)
//   long_inflight   out clog2(MAX_LONG+1) pending long-op count
//   hazard_timeout  out 1      sticky watchdog flag
// BEHAVIOUR
//   Reset: busy_vec=0, long_inflight=0, stall counter=0, hazard_timeout=0, FSM=RUN.
//   All hazard outputs combinational from inputs + registered state (zero-cycle decision).
//   load_use = ex_valid & ex_mem_read & ex_rd!=0 & ((id_use_rs1&rs1==ex_rd)|(id_use_rs2&rs2==ex_rd)).
//   sb_hit   = (id_use_rs1 & busy[rs1]) | (id_use_rs2 & busy[rs2]); busy[] seen pre-edge, but a
//              same-cycle long_done on that reg clears the hit (writeback bypass).
//   struct   = id_long_op & (long_inflight - long_done + (ex_valid&ex_long_op)) >= MAX_LONG.
//   stall    = id_valid & (load_use | sb_hit | struct).
//   Priority: branch_taken > stall. branch_taken: pc_write=1, if_id_write=1, if_id_flush=1,
//     control_mux=1 (squash ID). Else stall: pc_write=0, if_id_write=0, control_mux=1.
//     Else all 1 except control_mux=0, if_id_flush=0.
//   Scoreboard edge update: set busy[ex_rd] when ex_valid&ex_long_op&ex_rd!=0; clear
//     busy[long_done_rd] when long_done. Same reg set and clear same edge -> busy=1 (newer issue).
//   long_inflight: +1 on issue (incl. rd=x0), -1 on long_done, both -> unchanged; saturates at
//     0 and MAX_LONG (long_done at 0 ignored).
//   FSM RUN/STALL: RUN->STALL when stall & !branch_taken; STALL->RUN when stall deasserts or
//     branch_taken. Counter increments each STALL cycle, clears in RUN; reaching STALL_LIMIT
//     sets hazard_timeout (sticky until reset). Counter saturates.
//   Reset mid-stall: all state cleared asynchronously; outputs return to run values immediately.
// CONFIGURATION
//   HAZARD_STATS_EN defined: adds outputs stat_load_stalls, stat_sb_stalls, stat_flushes (32 b
//     each, wrapping, reset 0); one increments per cycle of the respective cause, load_use
//     counted before sb_hit, none counted on flush cycles. Undefined: ports and logic absent.
// TESTING
//   Load x5 in EX, ID reads rs1=x5 -> 1 cycle pc_write=0, control_mux=1; next cycle run.
//   Load x0 in EX, ID reads x0 -> no stall.
//   DIV issues rd=x7; ID reads x7 -> stall until long_done(x7); that cycle stall=0, busy[7]->0.
//   MAX_LONG=2 with 2 pending, ID MUL -> struct stall; long_done same cycle -> no stall.
//   Load-use plus branch_taken same cycle -> if_id_flush=1, pc_write=1, no stall count.
//   STALL_LIMIT=4, busy reg held 4 cycles -> hazard_timeout=1; assert reset mid-stall -> all 0.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit: load-use stall, long-op register scoreboard, long-op limit, branch flush, stall watchdog.
// Latency: all hazard outputs are combinational from inputs and registered state; state updates on the next edge.
// Backpressure: stall holds PC and IF/ID and bubbles ID/EX; a taken branch overrides any stall and squashes IF/ID.
//
// Ports:
//   clk, reset (async, active-high)
//   id_*       : IF/ID instruction sources and long-op flag
//   ex_*       : ID/EX instruction (load / long-op issue and destination)
//   long_done* : long-op writeback
//   branch_taken : EX resolved a taken branch/jump
//   pc_write, if_id_write, control_mux, if_id_flush : pipeline control
//   busy_vec, long_inflight, hazard_timeout : scoreboard state and sticky watchdog flag
// Optional feature macro: HAZARD_STATS_EN adds stat_load_stalls, stat_sb_stalls, stat_flushes.
module hazard_scoreboard #(
    parameter int REG_AW      = 5,
    parameter int MAX_LONG    = 2,
    parameter int STALL_LIMIT = 64,
    localparam int NUM_REGS   = 2**REG_AW,
    localparam int LW         = $clog2(MAX_LONG + 1),
    localparam int CW         = $clog2(STALL_LIMIT + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                id_valid,
    input  logic [REG_AW-1:0]   id_rs1,
    input  logic [REG_AW-1:0]   id_rs2,
    input  logic                id_use_rs1,
    input  logic                id_use_rs2,
    input  logic                id_long_op,
    input  logic                ex_valid,
    input  logic                ex_mem_read,
    input  logic                ex_long_op,
    input  logic [REG_AW-1:0]   ex_rd,
    input  logic                long_done,
    input  logic [REG_AW-1:0]   long_done_rd,
    input  logic                branch_taken,
    output logic                pc_write,
    output logic                if_id_write,
    output logic                control_mux,
    output logic                if_id_flush,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic [LW-1:0]       long_inflight,
    output logic                hazard_timeout
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]         stat_load_stalls,
    output logic [31:0]         stat_sb_stalls,
    output logic [31:0]         stat_flushes
`endif
);

    typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

    localparam logic [LW-1:0] MAX_CNT   = LW'(MAX_LONG);
    localparam logic [LW:0]   MAX_CMP   = (LW + 1)'(MAX_LONG);
    localparam logic [CW-1:0] LIMIT_CNT = CW'(STALL_LIMIT);

    state_t        state;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] stall_cnt_nxt;

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_nxt;
    logic [LW-1:0]       inflight_q;

    logic          issue;
    logic          done_eff;
    logic [LW:0]   projected;
    logic          load_use;
    logic          sb_hit1;
    logic          sb_hit2;
    logic          sb_hit;
    logic          struct_hz;
    logic          stall;
    logic          stall_eff;

    assign busy_vec      = busy_q;
    assign long_inflight = inflight_q;

    assign issue    = ex_valid & ex_long_op;
    // A writeback with nothing in flight is ignored, so it must not lower the projection either.
    assign done_eff = long_done & (inflight_q != '0);

    assign load_use = ex_valid & ex_mem_read & (ex_rd != '0) &
                      ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

    // Same-cycle writeback of the busy register bypasses the hit.
    assign sb_hit1 = id_use_rs1 & busy_q[id_rs1] & ~(long_done & (long_done_rd == id_rs1));
    assign sb_hit2 = id_use_rs2 & busy_q[id_rs2] & ~(long_done & (long_done_rd == id_rs2));
    assign sb_hit  = sb_hit1 | sb_hit2;

    // Occupancy as it will stand after this edge: pending, minus retiring, plus issuing.
    assign projected = {1'b0, inflight_q} + {{LW{1'b0}}, issue} - {{LW{1'b0}}, done_eff};
    assign struct_hz = id_long_op & (projected >= MAX_CMP);

    assign stall     = id_valid & (load_use | sb_hit | struct_hz);
    assign stall_eff = stall & ~branch_taken;

    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        control_mux = 1'b0;
        if_id_flush = 1'b0;
        if (branch_taken) begin
            if_id_flush = 1'b1;
            control_mux = 1'b1;
        end else if (stall) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            control_mux = 1'b1;
        end
    end

    // Clear first, then set: an issue and a retire to the same register leaves it busy (newer owner).
    always_comb begin
        busy_nxt = busy_q;
        if (long_done) begin
            busy_nxt[long_done_rd] = 1'b0;
        end
        if (issue && (ex_rd != '0)) begin
            busy_nxt[ex_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q     <= '0;
            inflight_q <= '0;
        end else begin
            busy_q <= busy_nxt;
            if (issue && !long_done) begin
                if (inflight_q != MAX_CNT) begin
                    inflight_q <= inflight_q + 1'b1;
                end
            end else if (!issue && long_done) begin
                if (inflight_q != '0) begin
                    inflight_q <= inflight_q - 1'b1;
                end
            end
        end
    end

    // stall_cnt holds the number of consecutive stall cycles so far; it is only meaningful in STALL.
    always_comb begin
        stall_cnt_nxt = '0;
        if (stall_eff) begin
            if (state == RUN) begin
                stall_cnt_nxt = CW'(1);
            end else if (stall_cnt == LIMIT_CNT) begin
                stall_cnt_nxt = stall_cnt;
            end else begin
                stall_cnt_nxt = stall_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= RUN;
            stall_cnt      <= '0;
            hazard_timeout <= 1'b0;
        end else begin
            stall_cnt <= stall_cnt_nxt;
            case (state)
                RUN:     if (stall_eff)  state <= STALL;
                STALL:   if (!stall_eff) state <= RUN;
                default: state <= RUN;
            endcase
            if (stall_cnt_nxt == LIMIT_CNT) begin
                hazard_timeout <= 1'b1;
            end
        end
    end

`ifdef HAZARD_STATS_EN
    // One cause per cycle: load-use wins over scoreboard; flush cycles count only as flushes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_load_stalls <= '0;
            stat_sb_stalls   <= '0;
            stat_flushes     <= '0;
        end else begin
            if (branch_taken) begin
                stat_flushes <= stat_flushes + 32'd1;
            end else if (id_valid && load_use) begin
                stat_load_stalls <= stat_load_stalls + 32'd1;
            end else if (id_valid && sb_hit) begin
                stat_sb_stalls <= stat_sb_stalls + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    localparam int MAXL  = 2;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, id_use_rs1, id_use_rs2, id_long_op;
    logic [4:0]  id_rs1, id_rs2, ex_rd, long_done_rd;
    logic        ex_valid, ex_mem_read, ex_long_op, long_done, branch_taken;
    logic        pc_write, if_id_write, control_mux, if_id_flush;
    logic [31:0] busy_vec;
    logic [1:0]  long_inflight;
    logic        hazard_timeout;
`ifdef HAZARD_STATS_EN
    logic [31:0] stat_load_stalls, stat_sb_stalls, stat_flushes;
`endif

    int tests = 0;
    int fails = 0;

    // Control pattern {pc_write, if_id_write, if_id_flush, control_mux}
    localparam logic [3:0] P_RUN   = 4'b1100;
    localparam logic [3:0] P_STALL = 4'b0001;
    localparam logic [3:0] P_FLUSH = 4'b1111;

    hazard_scoreboard #(.REG_AW(5), .MAX_LONG(MAXL), .STALL_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_long_op(id_long_op),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_long_op(ex_long_op), .ex_rd(ex_rd),
        .long_done(long_done), .long_done_rd(long_done_rd), .branch_taken(branch_taken),
        .pc_write(pc_write), .if_id_write(if_id_write), .control_mux(control_mux),
        .if_id_flush(if_id_flush), .busy_vec(busy_vec), .long_inflight(long_inflight),
        .hazard_timeout(hazard_timeout)
`ifdef HAZARD_STATS_EN
        , .stat_load_stalls(stat_load_stalls), .stat_sb_stalls(stat_sb_stalls),
        .stat_flushes(stat_flushes)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] ctl();
        return {pc_write, if_id_write, if_id_flush, control_mux};
    endfunction

    task automatic idle_inputs();
        id_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_long_op = 0;
        id_rs1 = 0; id_rs2 = 0; ex_valid = 0; ex_mem_read = 0; ex_long_op = 0;
        ex_rd = 0; long_done = 0; long_done_rd = 0; branch_taken = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick();
        reset = 0;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        #2;
        tests++; if (busy_vec !== 32'h0) begin fails++; $display("FAIL reset_busy got=%h exp=0", busy_vec); end
        tests++; if (long_inflight !== 2'd0) begin fails++; $display("FAIL reset_inflight got=%0d exp=0", long_inflight); end
        tests++; if (hazard_timeout !== 1'b0) begin fails++; $display("FAIL reset_timeout got=%b exp=0", hazard_timeout); end
        tests++; if (ctl() !== P_RUN) begin fails++; $display("FAIL reset_ctl got=%b exp=%b", ctl(), P_RUN); end
        tick();
        reset = 0;
        #1;
    endtask

    task automatic test_load_use();
        do_reset();
        ex_valid = 1; ex_mem_read = 1; ex_rd = 5;
        id_valid = 1; id_use_rs1 = 1; id_rs1 = 5;
        #1;
        tests++; if (ctl() !== P_STALL) begin fails++; $display("FAIL load_use_stall got=%b exp=%b", ctl(), P_STALL); end
        tick();
        ex_valid = 0; ex_mem_read = 0;
        #1;
        tests++; if (ctl() !== P_RUN) begin fails++; $display("FAIL load_use_release got=%b exp=%b", ctl(), P_RUN); end
        // rs2 path
        ex_valid = 1; ex_mem_read = 1; ex_rd = 9; id_use_rs1 = 0; id_use_rs2 = 1; id_rs2 = 9;
        #1;
        tests++; if (ctl() !== P_STALL) begin fails++; $display("FAIL load_use_rs2 got=%b exp=%b", ctl(), P_STALL); end
        // x0 destination never stalls
        ex_rd = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 1;
        #1;
        tests++; if (ctl() !== P_RUN) begin fails++; $display("FAIL load_x0 got=%b exp=%b", ctl(), P_RUN); end
        idle_inputs();
    endtask

    task automatic test_scoreboard();
        do_reset();
        ex_valid = 1; ex_long_op = 1; ex_rd = 7;
        tick();
        ex_valid = 0; ex_long_op = 0;
        tests++; if (busy_vec !== 32'h80) begin fails++; $display("FAIL sb_busy_set got=%h exp=80", busy_vec); end
        tests++; if (long_inflight !== 2'd1) begin fails++; $display("FAIL sb_inflight got=%0d exp=1", long_inflight); end
        id_valid = 1; id_use_rs1 = 1; id_rs1 = 7;
        for (int i = 0; i < 2; i++) begin
            #1;
            tests++; if (ctl() !== P_STALL) begin fails++; $display("FAIL sb_stall cyc=%0d got=%b exp=%b", i, ctl(), P_STALL); end
            tick();
        end
        long_done = 1; long_done_rd = 7;
        #1;
        tests++; if (ctl() !== P_RUN) begin fails++; $display("FAIL sb_bypass got=%b exp=%b", ctl(), P_RUN); end
        tick();
        long_done = 0;
        tests++; if (busy_vec !== 32'h0) begin fails++; $display("FAIL sb_busy_clear got=%h exp=0", busy_vec); end
        tests++; if (long_inflight !== 2'd0) begin fails++; $display("FAIL sb_inflight_clear got=%0d exp=0", long_inflight); end
        idle_inputs();
    endtask

    task automatic test_struct();
        do_reset();
        ex_valid = 1; ex_long_op = 1; ex_rd = 3;
        tick();
        ex_rd = 4;
        tick();
        ex_valid = 0; ex_long_op = 0;
        tests++; if (long_inflight !== 2'd2) begin fails++; $display("FAIL st_inflight got=%0d exp=2", long_inflight); end
        id_valid = 1; id_long_op = 1;
        #1;
        tests++; if (ctl() !== P_STALL) begin fails++; $display("FAIL st_full got=%b exp=%b", ctl(), P_STALL); end
        long_done = 1; long_done_rd = 3;
        #1;
        tests++; if (ctl() !== P_RUN) begin fails++; $display("FAIL st_done_bypass got=%b exp=%b", ctl(), P_RUN); end
        tick();
        long_done = 0;
        // one pending plus one issuing to x0 fills the limit
        ex_valid = 1; ex_long_op = 1; ex_rd = 0;
        #1;
        tests++; if (ctl() !== P_STALL) begin fails++; $display("FAIL st_issue got=%b exp=%b", ctl(), P_STALL); end
        tick();
        ex_valid = 0; ex_long_op = 0; id_valid = 0;
        tests++; if (long_inflight !== 2'd2) begin fails++; $display("FAIL st_x0_count got=%0d exp=2", long_inflight); end
        tests++; if (busy_vec !== 32'h10) begin fails++; $display("FAIL st_busy got=%h exp=10", busy_vec); end
        idle_inputs();
    endtask

    task automatic test_branch_and_timeout();
        do_reset();
        ex_valid = 1; ex_long_op = 1; ex_rd = 9;
        tick();
        ex_valid = 0; ex_long_op = 0;
        id_valid = 1; id_use_rs1 = 1; id_rs1 = 9;
        repeat (3) tick();
        // load-use and scoreboard hazard together with a taken branch
        ex_valid = 1; ex_mem_read = 1; ex_rd = 9; branch_taken = 1;
        #1;
        tests++; if (ctl() !== P_FLUSH) begin fails++; $display("FAIL br_flush got=%b exp=%b", ctl(), P_FLUSH); end
        tick();
        ex_valid = 0; ex_mem_read = 0; branch_taken = 0;
        repeat (3) tick();
        tests++; if (hazard_timeout !== 1'b0) begin fails++; $display("FAIL br_restarts_count got=%b exp=0", hazard_timeout); end
        tick();
        tests++; if (hazard_timeout !== 1'b1) begin fails++; $display("FAIL timeout_set got=%b exp=1", hazard_timeout); end
        repeat (2) tick();
        tests++; if (hazard_timeout !== 1'b1) begin fails++; $display("FAIL timeout_sticky got=%b exp=1", hazard_timeout); end
        // asynchronous reset with the hazard still presented
        #2 reset = 1;
        #1;
        tests++; if (hazard_timeout !== 1'b0 || busy_vec !== 32'h0 || long_inflight !== 2'd0) begin
            fails++; $display("FAIL midstall_reset_state to=%b busy=%h infl=%0d exp=0/0/0", hazard_timeout, busy_vec, long_inflight);
        end
        tests++; if (ctl() !== P_RUN) begin fails++; $display("FAIL midstall_reset_ctl got=%b exp=%b", ctl(), P_RUN); end
        tick();
        reset = 0;
        idle_inputs();
    endtask

    task automatic test_random();
        logic [31:0] m_busy;
        int m_infl, m_run;
        logic m_to;
        int pend[$];
        logic lu, sb, st, stl, iss;
        logic [3:0] exp_ctl;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (cyc % 60 == 0) begin
                do_reset();
                m_busy = 0; m_infl = 0; m_run = 0; m_to = 0; pend.delete();
            end
            id_valid     = 1'($urandom_range(0, 3) != 0);
            id_rs1       = 5'($urandom_range(0, 7));
            id_rs2       = 5'($urandom_range(0, 7));
            id_use_rs1   = 1'($urandom_range(0, 1));
            id_use_rs2   = 1'($urandom_range(0, 1));
            id_long_op   = 1'($urandom_range(0, 2) == 0);
            ex_valid     = 1'($urandom_range(0, 1));
            ex_mem_read  = 1'($urandom_range(0, 2) == 0);
            ex_long_op   = ~ex_mem_read & 1'($urandom_range(0, 2) == 0);
            ex_rd        = 5'($urandom_range(0, 7));
            branch_taken = 1'($urandom_range(0, 9) == 0);
            long_done    = 1'(m_infl > 0 && $urandom_range(0, 2) == 0);
            long_done_rd = 5'($urandom_range(0, 7));
            if (long_done && pend.size() > 0) begin
                int k = $urandom_range(0, pend.size() - 1);
                long_done_rd = 5'(pend[k]);
                pend.delete(k);
            end
            #1;
            iss = ex_valid & ex_long_op;
            lu = ex_valid && ex_mem_read && ex_rd != 0 &&
                 ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
            sb = (id_use_rs1 && m_busy[id_rs1] && !(long_done && long_done_rd == id_rs1)) ||
                 (id_use_rs2 && m_busy[id_rs2] && !(long_done && long_done_rd == id_rs2));
            st = id_long_op && (m_infl - int'(long_done) + int'(iss)) >= MAXL;
            stl = id_valid && (lu || sb || st);
            exp_ctl = branch_taken ? P_FLUSH : (stl ? P_STALL : P_RUN);
            tests++; if (ctl() !== exp_ctl) begin fails++; $display("FAIL rnd_ctl cyc=%0d got=%b exp=%b", cyc, ctl(), exp_ctl); end
            tests++; if (busy_vec !== m_busy) begin fails++; $display("FAIL rnd_busy cyc=%0d got=%h exp=%h", cyc, busy_vec, m_busy); end
            tests++; if (long_inflight !== 2'(m_infl)) begin fails++; $display("FAIL rnd_infl cyc=%0d got=%0d exp=%0d", cyc, long_inflight, m_infl); end
            tests++; if (hazard_timeout !== m_to) begin fails++; $display("FAIL rnd_timeout cyc=%0d got=%b exp=%b", cyc, hazard_timeout, m_to); end
            // advance the reference model to the state after this edge
            if (long_done) m_busy[long_done_rd] = 1'b0;
            if (iss && ex_rd != 0) m_busy[ex_rd] = 1'b1;
            if (iss) pend.push_back(int'(ex_rd));
            if (iss && !long_done) m_infl = (m_infl < MAXL) ? m_infl + 1 : MAXL;
            else if (!iss && long_done) m_infl = (m_infl > 0) ? m_infl - 1 : 0;
            if (stl && !branch_taken) m_run++; else m_run = 0;
            if (m_run >= LIMIT) m_to = 1'b1;
            @(posedge clk);
            #1;
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        fork
            begin
                #200000;
                $display("FAIL watchdog time limit reached");
                $fatal(1, "timeout");
            end
        join_none
        test_reset();
        test_load_use();
        test_scoreboard();
        test_struct();
        test_branch_and_timeout();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
